ddl_event_dispatch: RTL and testbench
=====================================

Name: ddl_event_dispatch

Overview:
- Schedules event readout onto the two DDL links of the SRU.
- Queues incoming event triggers and selects which links carry each event, based on per-link XOFF.
- Issues per-link start pulses, waits for every selected link's event-sent flag, then releases the event.
- Sits upstream of the per-link DDL senders, beside the event-sent combiner; supplies the link-usage mode.

Parameters:
TIMEOUT_CYC, 20000, cycles allowed in WAIT or RELEASE before abort (counter width 16 bits).
MAX_PEND, 8, maximum queued triggers (1..15).
CNT_W, 16, width of the dispatched-event counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
trig_evt  in  1  one-cycle pulse: one event is ready for readout
ddl_xoff  in  2  per-link flow control; bit0 = link0, bit1 = link1; 1 = link unavailable
ddl_event_send_i  in  2  per-link level; high once the link has finished its part, held until cleared by the sender
ddl_start  out  2  one-cycle start pulse per link
ddl_mode  out  2  links used by the current event; stable from START until IDLE
evt_busy  out  1  high in every state except IDLE
evt_done  out  1  one-cycle pulse on successful completion
evt_timeout  out  1  one-cycle pulse on abort
pend_cnt  out  4  queued triggers
pend_ovf  out  1  sticky; set when a trigger is dropped at full queue
evt_cnt  out  CNT_W  successfully completed events; wraps modulo 2^CNT_W

Behaviour:
- Reset (async, any state): all outputs 0, state IDLE, timer 0.
- Queue:
  - trig_evt increments pend_cnt.
  - A START cycle decrements pend_cnt.
  - trig_evt in a START cycle: pend_cnt unchanged.
  - trig_evt with pend_cnt == MAX_PEND and no START that cycle: trigger dropped, pend_ovf <= 1. pend_ovf clears only on reset.
- States: IDLE, SELECT, START, WAIT, RELEASE, ABORT.
- IDLE: go to SELECT if pend_cnt != 0 and ddl_xoff != 2'b11. Otherwise stay.
- SELECT: ddl_mode <= ~ddl_xoff, sampled this cycle.
  - If ddl_xoff == 2'b11 this cycle, return to IDLE; ddl_mode is not updated.
  - Otherwise go to START.
- START:
  - ddl_start <= ddl_mode, high for exactly one cycle.
  - pend_cnt decrements; timer loads TIMEOUT_CYC.
  - Go to WAIT.
- WAIT:
  - Go to RELEASE when (ddl_event_send_i & ddl_mode) == ddl_mode.
  - Unselected link bits are ignored.
  - XOFF changes during WAIT are ignored.
  - Timer decrements each cycle; reaching 0 goes to ABORT.
- RELEASE: entered with timer reloaded to TIMEOUT_CYC.
  - When (ddl_event_send_i & ddl_mode) == 0: evt_done pulses, evt_cnt increments, go to IDLE.
  - Timer expiry goes to ABORT.
- ABORT: evt_timeout pulses for one cycle; evt_cnt is unchanged; go to IDLE.
- Latency: trig_evt in cycle N with the FSM idle and a free link gives ddl_start in cycle N+3 (pend_cnt visible N+1, SELECT N+2, START N+3).
- Back-to-back: after IDLE the next queued event is scheduled with no extra gap.
- Reset mid-event: the queue is lost and no done or timeout pulse is generated.

Optional Feature:
EVT_RETRY_EN
- Defined: the first timeout of an event re-enters SELECT, re-samples XOFF and restarts. pend_cnt is not decremented again. evt_timeout pulses only if the retry also times out. A 1-bit retry flag clears in IDLE.
- Undefined: a timeout always goes to ABORT, and the event is dropped.

Test Plan:
- Both links free, one trig_evt, each send_i high 10 cycles after its start, then low 5 cycles later -> ddl_start=11 at N+3, ddl_mode=11, evt_done once, evt_cnt=1, pend_cnt=0.
- ddl_xoff=01 during SELECT -> ddl_mode=10, ddl_start=10; send_i=10 alone completes; send_i[0] toggling has no effect.
- ddl_xoff=11 with pend_cnt=2 -> no start, busy stays 0; xoff released -> two events complete in order, evt_cnt=2.
- 9 trig_evt pulses with links xoff'd (MAX_PEND=8) -> pend_cnt=8, pend_ovf=1.
- send_i never asserted, TIMEOUT_CYC=20 -> evt_timeout 21 cycles after START, evt_cnt unchanged, next event proceeds; with EVT_RETRY_EN, a second start occurs first.
- Reset asserted mid-WAIT -> all outputs 0 asynchronously, FSM IDLE; trig_evt after release dispatches normally.

Source files
------------

// File: rtl/ddl_event_dispatch_if.sv
// ----------------------------------------------------------------------------
// ddl_event_dispatch_if
// Bundles the trigger, per-link flow-control/handshake and status signals of
// the DDL event dispatcher.
//   trig_evt          : one-cycle "event ready" pulse
//   ddl_xoff[1:0]     : per-link unavailable flag (bit0 = link0)
//   ddl_event_send_i  : per-link "my part is sent" level
//   ddl_start[1:0]    : one-cycle per-link start pulse
//   ddl_mode[1:0]     : links used by the current event
//   evt_busy/evt_done/evt_timeout : dispatcher status and completion pulses
//   pend_cnt/pend_ovf : trigger queue depth and sticky drop flag
//   evt_cnt           : completed-event counter
// Modports: slave = dispatcher side, master = environment side.
// ----------------------------------------------------------------------------
interface ddl_event_dispatch_if #(
    parameter int unsigned CNT_W = 16
);
    logic             trig_evt;
    logic [1:0]       ddl_xoff;
    logic [1:0]       ddl_event_send_i;
    logic [1:0]       ddl_start;
    logic [1:0]       ddl_mode;
    logic             evt_busy;
    logic             evt_done;
    logic             evt_timeout;
    logic [3:0]       pend_cnt;
    logic             pend_ovf;
    logic [CNT_W-1:0] evt_cnt;

    modport slave (
        input  trig_evt, ddl_xoff, ddl_event_send_i,
        output ddl_start, ddl_mode, evt_busy, evt_done, evt_timeout,
               pend_cnt, pend_ovf, evt_cnt
    );

    modport master (
        output trig_evt, ddl_xoff, ddl_event_send_i,
        input  ddl_start, ddl_mode, evt_busy, evt_done, evt_timeout,
               pend_cnt, pend_ovf, evt_cnt
    );
endinterface

// File: rtl/ddl_event_dispatch.sv
// ----------------------------------------------------------------------------
// ddl_event_dispatch
// Queues event triggers and schedules each event onto the two DDL links of
// the SRU: picks the links not under XOFF, pulses their start, waits for every
// selected link to report sent, waits for the flags to clear, then releases.
// A watchdog aborts an event stuck in WAIT or RELEASE.
// Ports:
//   clk   : system clock
//   reset : asynchronous reset, active-high
//   bus   : ddl_event_dispatch_if.slave (trigger, XOFF, send flags, status)
// Build option: EVT_RETRY_EN - first timeout of an event re-selects links and
//   restarts it once before aborting.
// ----------------------------------------------------------------------------
module ddl_event_dispatch #(
    parameter int unsigned TIMEOUT_CYC = 20000,
    parameter int unsigned MAX_PEND    = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    ddl_event_dispatch_if.slave  bus
);
    localparam int unsigned TMR_W  = 16;
    localparam int unsigned PEND_W = 4;
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT_CYC);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_START, S_WAIT, S_RELEASE, S_ABORT
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         start_q, start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tmo_q, tmo_d;
    logic               ovf_q, ovf_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               take_c;
    logic               expire_c;
    logic               tmo_hit_c;
    logic [1:0]         sent_c;
`ifdef EVT_RETRY_EN
    logic               retry_q, retry_d;
`endif

    // Only the links selected for this event take part in the handshake.
    assign sent_c   = bus.ddl_event_send_i & mode_q;
    assign expire_c = (timer_q <= TMR_W'(1));

    // A retried START re-launches an event that already left the queue.
`ifdef EVT_RETRY_EN
    assign take_c = (state_q == S_START) && !retry_q;
`else
    assign take_c = (state_q == S_START);
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mode_d    = mode_q;
        start_d   = 2'b00;
        done_d    = 1'b0;
        tmo_d     = 1'b0;
        ovf_d     = ovf_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        tmo_hit_c = 1'b0;
`ifdef EVT_RETRY_EN
        retry_d   = retry_q;
`endif

        // Trigger queue; a trigger coinciding with a dequeue nets to zero.
        if (bus.trig_evt && !take_c) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (!bus.trig_evt && take_c) begin
            pend_d = pend_q - PEND_W'(1);
        end

        case (state_q)
            S_IDLE: begin
`ifdef EVT_RETRY_EN
                retry_d = 1'b0;
`endif
                if (pend_q != '0 && bus.ddl_xoff != 2'b11) begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (bus.ddl_xoff == 2'b11) begin
                    state_d = S_IDLE;
                end else begin
                    mode_d  = ~bus.ddl_xoff;
                    start_d = ~bus.ddl_xoff;
                    state_d = S_START;
                end
            end
            S_START: begin
                timer_d = TMR_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sent_c == mode_q) begin
                    timer_d = TMR_LOAD;
                    state_d = S_RELEASE;
                end else if (expire_c) begin
                    tmo_hit_c = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_RELEASE: begin
                if (sent_c == 2'b00) begin
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_IDLE;
                end else if (expire_c) begin
                    tmo_hit_c = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog expiry: abort, or one restart when retry is built in.
        if (tmo_hit_c) begin
            timer_d = '0;
`ifdef EVT_RETRY_EN
            if (!retry_q) begin
                retry_d = 1'b1;
                state_d = S_SELECT;
            end else begin
                tmo_d   = 1'b1;
                state_d = S_ABORT;
            end
`else
            tmo_d   = 1'b1;
            state_d = S_ABORT;
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            mode_q  <= '0;
            start_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            ovf_q   <= 1'b0;
            pend_q  <= '0;
            cnt_q   <= '0;
`ifdef EVT_RETRY_EN
            retry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            mode_q  <= mode_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
`ifdef EVT_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign bus.ddl_start   = start_q;
    assign bus.ddl_mode    = mode_q;
    assign bus.evt_busy    = busy_q;
    assign bus.evt_done    = done_q;
    assign bus.evt_timeout = tmo_q;
    assign bus.pend_cnt    = pend_q;
    assign bus.pend_ovf    = ovf_q;
    assign bus.evt_cnt     = cnt_q;

endmodule

// File: tb/tb_ddl_event_dispatch.sv
// ----------------------------------------------------------------------------
// tb_ddl_event_dispatch
// Directed bench for ddl_event_dispatch (TIMEOUT_CYC=20, MAX_PEND=8).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_ddl_event_dispatch;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ddl_event_dispatch_if #(.CNT_W(CNT_W)) ifc ();

    ddl_event_dispatch #(
        .TIMEOUT_CYC (20),
        .MAX_PEND    (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int n_assert  = 0;
    int n_fail    = 0;
    int done_seen = 0;
    int tmo_seen  = 0;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (ifc.evt_done === 1'b1)    done_seen++;
        if (ifc.evt_timeout === 1'b1) tmo_seen++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until evt_done is seen, bounded.
    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ifc.evt_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic pulse_trig();
        ifc.trig_evt = 1'b1;
        step(1);
        ifc.trig_evt = 1'b0;
    endtask

    bit ok;
    int d0, t0;

    initial begin
        reset                = 1'b1;
        ifc.trig_evt         = 1'b0;
        ifc.ddl_xoff         = 2'b00;
        ifc.ddl_event_send_i = 2'b00;
        step(2);

        // Reset values
        chk("rst_busy",  32'(ifc.evt_busy),    32'd0);
        chk("rst_start", 32'(ifc.ddl_start),   32'd0);
        chk("rst_mode",  32'(ifc.ddl_mode),    32'd0);
        chk("rst_pend",  32'(ifc.pend_cnt),    32'd0);
        chk("rst_ovf",   32'(ifc.pend_ovf),    32'd0);
        chk("rst_cnt",   32'(ifc.evt_cnt),     32'd0);
        chk("rst_done",  32'(ifc.evt_done),    32'd0);
        chk("rst_tmo",   32'(ifc.evt_timeout), 32'd0);
        reset = 1'b0;
        step(1);

        // Both links free, single event, latency N+3
        pulse_trig();                                           // N+1
        chk("t1_pend_n1", 32'(ifc.pend_cnt), 32'd1);
        chk("t1_busy_n1", 32'(ifc.evt_busy), 32'd0);
        step(1);                                                // N+2
        chk("t1_busy_n2",  32'(ifc.evt_busy),  32'd1);
        chk("t1_start_n2", 32'(ifc.ddl_start), 32'd0);
        step(1);                                                // N+3
        chk("t1_start_n3", 32'(ifc.ddl_start), 32'b11);
        chk("t1_mode_n3",  32'(ifc.ddl_mode),  32'b11);
        step(1);                                                // N+4
        chk("t1_start_n4", 32'(ifc.ddl_start), 32'd0);
        chk("t1_pend_n4",  32'(ifc.pend_cnt),  32'd0);
        step(9);                                                // N+13
        ifc.ddl_event_send_i = 2'b11;
        step(5);                                                // N+18
        chk("t1_done_early", 32'(ifc.evt_done), 32'd0);
        chk("t1_busy_rel",   32'(ifc.evt_busy), 32'd1);
        ifc.ddl_event_send_i = 2'b00;
        step(1);                                                // N+19
        chk("t1_done",  32'(ifc.evt_done), 32'd1);
        chk("t1_cnt",   32'(ifc.evt_cnt),  32'd1);
        chk("t1_idle",  32'(ifc.evt_busy), 32'd0);
        step(1);
        chk("t1_done_pulse", 32'(ifc.evt_done), 32'd0);
        chk("t1_done_once",  32'(done_seen),    32'd1);

        // Link0 under XOFF: only link1 is used
        ifc.ddl_xoff = 2'b01;
        pulse_trig();
        step(2);                                                // c0
        chk("t2_start", 32'(ifc.ddl_start), 32'b10);
        chk("t2_mode",  32'(ifc.ddl_mode),  32'b10);
        step(1);
        ifc.ddl_event_send_i = 2'b01;
        step(3);                                                // c0+4
        chk("t2_wait_busy", 32'(ifc.evt_busy), 32'd1);
        chk("t2_wait_done", 32'(done_seen),    32'd1);
        ifc.ddl_event_send_i = 2'b10;
        step(1);                                                // c0+5 RELEASE
        ifc.ddl_event_send_i = 2'b11;
        step(2);                                                // c0+7
        chk("t2_rel_busy", 32'(ifc.evt_busy), 32'd1);
        chk("t2_rel_done", 32'(done_seen),    32'd1);
        ifc.ddl_event_send_i = 2'b01;
        step(1);                                                // c0+8
        chk("t2_done", 32'(ifc.evt_done), 32'd1);
        chk("t2_cnt",  32'(ifc.evt_cnt),  32'd2);
        ifc.ddl_event_send_i = 2'b00;
        ifc.ddl_xoff         = 2'b00;
        step(1);

        // Both links under XOFF with two queued events, then release
        ifc.ddl_xoff = 2'b11;
        pulse_trig();
        step(1);
        pulse_trig();
        step(4);
        chk("t3_pend2", 32'(ifc.pend_cnt),  32'd2);
        chk("t3_busy0", 32'(ifc.evt_busy),  32'd0);
        chk("t3_nostart", 32'(ifc.ddl_start), 32'd0);
        ifc.ddl_xoff = 2'b00;
        step(1);                                                // r+1
        chk("t3_sel_busy", 32'(ifc.evt_busy), 32'd1);
        step(1);                                                // r+2
        chk("t3_start_a", 32'(ifc.ddl_start), 32'b11);
        step(1);                                                // r+3
        chk("t3_pend_a", 32'(ifc.pend_cnt), 32'd1);
        ifc.ddl_event_send_i = 2'b11;
        step(2);
        ifc.ddl_event_send_i = 2'b00;
        wait_done(ok);
        chk("t3_done_a_seen", 32'(ok), 32'd1);
        chk("t3_cnt_a", 32'(ifc.evt_cnt), 32'd3);
        step(2);                                                // d+2, no gap
        chk("t3_start_b", 32'(ifc.ddl_start), 32'b11);
        step(1);
        chk("t3_pend_b", 32'(ifc.pend_cnt), 32'd0);
        ifc.ddl_event_send_i = 2'b11;
        step(2);
        ifc.ddl_event_send_i = 2'b00;
        wait_done(ok);
        chk("t3_done_b_seen", 32'(ok), 32'd1);
        chk("t3_cnt_b", 32'(ifc.evt_cnt), 32'd4);
        step(1);

        // Watchdog: send flags never raised
        t0 = tmo_seen;
        pulse_trig();
        step(2);                                                // S
        chk("t5_start", 32'(ifc.ddl_start), 32'b11);
        step(5);                                                // S+5
        pulse_trig();                                           // S+6
        chk("t5_pend_q", 32'(ifc.pend_cnt), 32'd1);
`ifdef EVT_RETRY_EN
        step(15);                                               // S+21
        chk("t5_no_tmo_1st", 32'(ifc.evt_timeout), 32'd0);
        chk("t5_retry_busy", 32'(ifc.evt_busy),    32'd1);
        step(1);                                                // S+22
        chk("t5_restart", 32'(ifc.ddl_start), 32'b11);
        step(1);
        chk("t5_pend_keep", 32'(ifc.pend_cnt), 32'd1);
        step(19);                                               // S+42
        chk("t5_tmo_early", 32'(ifc.evt_timeout), 32'd0);
        step(1);                                                // S+43
`else
        step(14);                                               // S+20
        chk("t5_tmo_early", 32'(ifc.evt_timeout), 32'd0);
        step(1);                                                // S+21
`endif
        chk("t5_tmo",     32'(ifc.evt_timeout), 32'd1);
        chk("t5_cnt",     32'(ifc.evt_cnt),     32'd4);
        step(1);
        chk("t5_tmo_pulse", 32'(ifc.evt_timeout), 32'd0);
        chk("t5_idle",      32'(ifc.evt_busy),    32'd0);
        step(2);
        chk("t5_next_start", 32'(ifc.ddl_start), 32'b11);
        step(1);
        ifc.ddl_event_send_i = 2'b11;
        step(2);
        ifc.ddl_event_send_i = 2'b00;
        wait_done(ok);
        chk("t5_next_done", 32'(ok), 32'd1);
        chk("t5_next_cnt",  32'(ifc.evt_cnt), 32'd5);
        chk("t5_tmo_once",  32'(tmo_seen - t0), 32'd1);
        step(1);

        // Reset in the middle of WAIT
        pulse_trig();
        step(2);
        chk("t6_start", 32'(ifc.ddl_start), 32'b11);
        step(3);
        d0 = done_seen;
        t0 = tmo_seen;
        reset = 1'b1;
        #1;
        chk("t6_async_busy", 32'(ifc.evt_busy), 32'd0);
        chk("t6_async_mode", 32'(ifc.ddl_mode), 32'd0);
        chk("t6_async_cnt",  32'(ifc.evt_cnt),  32'd0);
        step(1);
        reset = 1'b0;
        step(2);
        chk("t6_no_pulses", 32'((done_seen - d0) + (tmo_seen - t0)), 32'd0);
        chk("t6_idle",      32'(ifc.evt_busy), 32'd0);
        pulse_trig();
        chk("t6_pend", 32'(ifc.pend_cnt), 32'd1);
        step(2);
        chk("t6_restart", 32'(ifc.ddl_start), 32'b11);
        step(1);
        ifc.ddl_event_send_i = 2'b11;
        step(2);
        ifc.ddl_event_send_i = 2'b00;
        wait_done(ok);
        chk("t6_done", 32'(ok), 32'd1);
        chk("t6_cnt",  32'(ifc.evt_cnt), 32'd1);
        step(1);

        // Queue overflow with both links under XOFF
        ifc.ddl_xoff = 2'b11;
        for (int i = 0; i < 8; i++) pulse_trig();
        chk("t4_pend8", 32'(ifc.pend_cnt), 32'd8);
        chk("t4_ovf0",  32'(ifc.pend_ovf), 32'd0);
        pulse_trig();
        chk("t4_pend_sat", 32'(ifc.pend_cnt), 32'd8);
        chk("t4_ovf1",     32'(ifc.pend_ovf), 32'd1);
        step(3);
        chk("t4_ovf_sticky", 32'(ifc.pend_ovf), 32'd1);
        chk("t4_busy0",      32'(ifc.evt_busy), 32'd0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        chk("t4_ovf_rst",  32'(ifc.pend_ovf), 32'd0);
        chk("t4_pend_rst", 32'(ifc.pend_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
